// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_loader
//  Description : Instruction memory for the IF stage with a byte-serial boot
//                loader. Fetches are answered combinationally. The loader
//                fills the memory word by word, MSB first, and holds the
//                pipeline through o_stall_req while a load is running.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, all state updates on posedge
//    rst          in   1   synchronous active-high reset
//    i_ce         in   1   fetch enable from the PC stage
//    i_addr       in   32  fetch byte address (pc)
//    o_inst       out  32  fetched instruction word (0 when not valid)
//    o_addr_err   out  1   fetch address misaligned or out of range
//    i_ld_start   in   1   pulse: begin a load at word 0
//    i_ld_valid   in   1   i_ld_byte valid this cycle
//    i_ld_byte    in   8   loader data byte
//    i_ld_last    in   1   marks the final byte of the image
//    o_ld_ready   out  1   loader accepts a byte this cycle
//    o_ld_done    out  1   one-cycle pulse when a load finishes
//    o_ld_ovf     out  1   sticky: image exceeded memory depth
//    o_stall_req  out  1   pipeline stall request
// ============================================================================
module inst_rom_loader #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ce,
   input  logic [31:0] i_addr,
   output logic [31:0] o_inst,
   output logic        o_addr_err,
   input  logic        i_ld_start,
   input  logic        i_ld_valid,
   input  logic [7:0]  i_ld_byte,
   input  logic        i_ld_last,
   output logic        o_ld_ready,
   output logic        o_ld_done,
   output logic        o_ld_ovf,
   output logic        o_stall_req
);

   localparam int              c_DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] c_LAST_WORD = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_wptr;
   logic [1:0]          r_bcnt;
   logic [31:0]         r_shift;
   logic                r_ld_done;
   logic                r_ld_ovf;
   logic                r_stall_req;
   logic                r_ld_ready;

   // Memory has no reset; contents survive a reset mid-load.
   logic [31:0]         r_mem [0:c_DEPTH-1];

   logic [ADDR_W-1:0]   w_widx;
   logic                w_addr_err;
   logic                w_accept;
   logic                w_wr;
   logic [31:0]         w_word;

   // ---------------------------------------------------------------- fetch
   assign w_widx     = i_addr[ADDR_W+1:2];
   assign w_addr_err = i_ce & ((i_addr[1:0] != 2'b00) | (i_addr[31:ADDR_W+2] != '0));

   assign o_addr_err = w_addr_err;
   assign o_inst     = (i_ce && !w_addr_err && (r_state != S_LOAD)) ? r_mem[w_widx] : 32'd0;

   // --------------------------------------------------------------- loader
   assign w_accept = (r_state == S_LOAD) & i_ld_valid;
   // A word is committed on its 4th byte, or early on the last image byte
   // (unfilled low bytes are still zero in the shift register).
   assign w_wr     = w_accept & ((r_bcnt == 2'd3) | i_ld_last);
   // Byte k of a word lands at bits [31-8k:24-8k].
   assign w_word   = r_shift | ({24'd0, i_ld_byte} << {(2'd3 - r_bcnt), 3'b000});

   always_ff @(posedge clk) begin
      if (w_wr && !rst) begin
         r_mem[r_wptr] <= w_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wptr      <= '0;
         r_bcnt      <= 2'd0;
         r_shift     <= 32'd0;
         r_ld_done   <= 1'b0;
         r_ld_ovf    <= 1'b0;
         r_stall_req <= 1'b0;
         r_ld_ready  <= 1'b0;
      end else begin
         r_ld_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_ld_start) begin
                  r_state     <= S_LOAD;
                  r_wptr      <= '0;
                  r_bcnt      <= 2'd0;
                  r_shift     <= 32'd0;
                  r_ld_ovf    <= 1'b0;
                  r_stall_req <= 1'b1;
                  r_ld_ready  <= 1'b1;
               end
            end
            S_LOAD: begin
               // i_ld_start is deliberately ignored here.
               if (w_accept) begin
                  if (w_wr) begin
                     r_bcnt  <= 2'd0;
                     r_shift <= 32'd0;
                     r_wptr  <= r_wptr + 1'b1;
                     if (i_ld_last || (r_wptr == c_LAST_WORD)) begin
                        r_state     <= S_DONE;
                        r_ld_done   <= 1'b1;
                        r_stall_req <= 1'b0;
                        r_ld_ready  <= 1'b0;
                        // Memory filled before the image ended.
                        if (!i_ld_last) begin
                           r_ld_ovf <= 1'b1;
                        end
                     end
                  end else begin
                     r_bcnt  <= r_bcnt + 2'd1;
                     r_shift <= w_word;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_ld_ready  = r_ld_ready;
   assign o_ld_done   = r_ld_done;
   assign o_ld_ovf    = r_ld_ovf;
   assign o_stall_req = r_stall_req;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_rom_loader
//  Description : Directed testbench for inst_rom_loader. Three instances:
//                ADDR_W=10 (main), ADDR_W=2 (overflow), ADDR_W=4 (range).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;

   // main instance
   logic        ld_start, ld_valid, ld_last;
   logic [7:0]  ld_byte;
   logic [31:0] inst;
   logic        aerr, ld_ready, ld_done, ld_ovf, stall;

   // ADDR_W=2 instance
   logic        s_start, s_valid, s_last;
   logic [7:0]  s_byte;
   logic [31:0] s_inst;
   logic        s_aerr, s_ready, s_done, s_ovf, s_stall;

   // ADDR_W=4 instance (fetch only)
   logic [31:0] f_inst;
   logic        f_aerr, f_ready, f_done, f_ovf, f_stall;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   inst_rom_loader #(.ADDR_W(10)) u_dut (
      .clk(clk), .rst(rst), .i_ce(ce), .i_addr(addr),
      .o_inst(inst), .o_addr_err(aerr),
      .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_byte(ld_byte), .i_ld_last(ld_last),
      .o_ld_ready(ld_ready), .o_ld_done(ld_done), .o_ld_ovf(ld_ovf), .o_stall_req(stall)
   );

   inst_rom_loader #(.ADDR_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .i_ce(ce), .i_addr(addr),
      .o_inst(s_inst), .o_addr_err(s_aerr),
      .i_ld_start(s_start), .i_ld_valid(s_valid), .i_ld_byte(s_byte), .i_ld_last(s_last),
      .o_ld_ready(s_ready), .o_ld_done(s_done), .o_ld_ovf(s_ovf), .o_stall_req(s_stall)
   );

   inst_rom_loader #(.ADDR_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .i_ce(ce), .i_addr(addr),
      .o_inst(f_inst), .o_addr_err(f_aerr),
      .i_ld_start(1'b0), .i_ld_valid(1'b0), .i_ld_byte(8'h00), .i_ld_last(1'b0),
      .o_ld_ready(f_ready), .o_ld_done(f_done), .o_ld_ovf(f_ovf), .o_stall_req(f_stall)
   );

   typedef struct {
      logic        sel;       // 0: ADDR_W=10 instance, 1: ADDR_W=4 instance
      logic        ce;
      logic [31:0] addr;
      logic        chk_inst;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // inputs change 2 ns after the rising edge, outputs sampled before the next
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_ld();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      ce   = 1'b1;
      addr = a;
      #1;
      chk(name, inst, exp);
      ce   = 1'b0;
   endtask

   initial begin
      logic [7:0] img1 [8];
      img1 = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};

      vt[0]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hAABB_CCDD, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h1122_0000, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b1};
      vt[3]  = '{1'b0, 1'b0, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_0000, 1'b1};
      vt[6]  = '{1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1};
      vt[7]  = '{1'b0, 1'b1, 32'h0000_0FFC, 1'b0, 32'h0000_0000, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0000, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 32'h0000_003C, 1'b0, 32'h0000_0000, 1'b0};
      vt[10] = '{1'b1, 1'b0, 32'h0000_0040, 1'b1, 32'h0000_0000, 1'b0};

      rst = 1'b1; ce = 1'b0; addr = 32'd0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0; ld_last = 1'b0;
      s_start = 1'b0; s_valid = 1'b0; s_byte = 8'd0; s_last = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_done",  {31'd0, ld_done},  32'd0);
      chk("rst_ovf",   {31'd0, ld_ovf},   32'd0);
      chk("rst_stall", {31'd0, stall},    32'd0);

      // test 1: two full words
      start_ld();
      chk("t1_stall_hi", {31'd0, stall},    32'd1);
      chk("t1_ready_hi", {31'd0, ld_ready}, 32'd1);
      fetch_chk("t1_fetch_in_load", 32'h0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         send(img1[i], (i == 7));
      end
      chk("t1_done_pulse", {31'd0, ld_done}, 32'd1);
      chk("t1_stall_lo",   {31'd0, stall},   32'd0);
      chk("t1_ovf",        {31'd0, ld_ovf},  32'd0);
      tick();
      chk("t1_done_clear", {31'd0, ld_done}, 32'd0);
      fetch_chk("t1_mem0", 32'h0, 32'h3401_1100);
      fetch_chk("t1_mem1", 32'h4, 32'h3402_0020);

      // test 2: partial final word
      start_ld();
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
      send(8'hDD, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b1);
      chk("t2_done", {31'd0, ld_done}, 32'd1);
      chk("t2_ovf",  {31'd0, ld_ovf},  32'd0);
      tick();

      // test 3: fetch table
      for (int i = 0; i < 11; i++) begin
         ce   = vt[i].ce;
         addr = vt[i].addr;
         #1;
         if (vt[i].sel == 1'b0) begin
            if (vt[i].chk_inst) chk($sformatf("vec%0d_inst", i), inst, vt[i].inst);
            chk($sformatf("vec%0d_err", i), {31'd0, aerr}, {31'd0, vt[i].err});
         end else begin
            if (vt[i].chk_inst) chk($sformatf("vec%0d_inst", i), f_inst, vt[i].inst);
            chk($sformatf("vec%0d_err", i), {31'd0, f_aerr}, {31'd0, vt[i].err});
         end
      end
      ce = 1'b0;
      tick();

      // test 4: overflow on the ADDR_W=2 instance
      s_start = 1'b1; tick(); s_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1;
         s_byte  = 8'(i + 1);
         #1;
         chk($sformatf("t4_ready_b%0d", i + 1), {31'd0, s_ready}, (i < 16) ? 32'd1 : 32'd0);
         tick();
         if (i == 15) begin
            chk("t4_done", {31'd0, s_done}, 32'd1);
            chk("t4_ovf",  {31'd0, s_ovf},  32'd1);
         end
      end
      s_valid = 1'b0;
      chk("t4_ovf_sticky", {31'd0, s_ovf}, 32'd1);
      for (int w = 0; w < 4; w++) begin
         logic [31:0] e;
         e = {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)};
         ce = 1'b1; addr = 32'(4*w); #1;
         chk($sformatf("t4_mem%0d", w), s_inst, e);
      end
      addr = 32'h10; #1;
      chk("t4_range_err", {31'd0, s_aerr}, 32'd1);
      ce = 1'b0;
      tick();

      // test 5: reset mid-load
      start_ld();
      send(8'h55, 1'b0); send(8'h66, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_stall", {31'd0, stall},    32'd0);
      chk("t5_ready", {31'd0, ld_ready}, 32'd0);
      fetch_chk("t5_mem0_kept", 32'h0, 32'hAABB_CCDD);
      start_ld();
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
      tick();
      fetch_chk("t5_mem0_new", 32'h0, 32'h0102_0304);
      fetch_chk("t5_mem1_kept", 32'h4, 32'h1122_0000);

      // test 6: ld_start mid-load is ignored
      start_ld();
      send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0);
      start_ld();
      chk("t6_stall", {31'd0, stall}, 32'd1);
      send(8'hEF, 1'b1);
      chk("t6_done", {31'd0, ld_done}, 32'd1);
      tick();
      fetch_chk("t6_mem0", 32'h0, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
